alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 29 ++
 rtl/alu_seq_mul.sv | 70 +++++++
 rtl/alu_seq.sv | 168 ++++++++++++++++
 tb/tb_alu_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcode/state enums and flag bit positions for alu_seq
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_INC   = 4'd5,
    OP_PASSA = 4'd6,
    OP_PASSB = 4'd7,
    OP_SHL   = 4'd8,
    OP_SRA   = 4'd9,
    OP_CMP   = 4'd10,
    OP_MUL   = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int FLAG_OVF  = 2;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_ZERO = 0;

endpackage

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - signed iterative shift-add multiplier, one multiplier bit per cycle
module alu_seq_mul
  import alu_seq_pkg::*;
#(
  parameter int BW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [BW-1:0]   a,
  input  logic [BW-1:0]   b,
  output logic            busy,
  output logic            done,
  output logic [2*BW-1:0] product
);

  localparam int CW = $clog2(BW + 1);

  logic [2*BW-1:0] mcand_q, mcand_d;
  logic [2*BW-1:0] acc_q, acc_d;
  logic [BW-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == CW'(BW));
  assign product = acc_q;

  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {{BW{a[BW-1]}}, a};
      mplier_d = b;
    end else if (done) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      // The multiplier MSB carries negative weight in two's complement.
      if (mplier_q[0]) begin
        acc_d = (cnt_q == CW'(BW - 1)) ? acc_q - mcand_q : acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked sequential ALU; define ALU_SEQ_MUL_EN to enable the iterative MUL opcode
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int BW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BW-1:0]   in_a,
  input  logic [BW-1:0]   in_b,
  input  logic [3:0]      opcode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*BW-1:0] out,
  output logic [2:0]      flags,
  output logic            out_err
);

  localparam int SHW = $clog2(BW);

  state_e          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [2*BW-1:0] out_q, out_d;
  logic [2:0]      flags_q, flags_d;
  logic            err_q, err_d;

  logic signed [BW:0] ax, bx, res;
  logic               arith, ovf_c, err_c, accept;
  logic [2*BW-1:0]    single_out;
  logic [2:0]         single_flags;

`ifdef ALU_SEQ_MUL_EN
  logic            mul_start, mul_busy, mul_done;
  logic [2*BW-1:0] mul_p;
  logic [2:0]      mul_flags;
  logic [BW:0]     mul_hi;

  alu_seq_mul #(.BW(BW)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (in_a),
    .b       (in_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_p)
  );

  // Product fits BW signed bits only when the top BW+1 bits are all equal.
  always_comb begin
    mul_hi                = mul_p[2*BW-1:BW-1];
    mul_flags             = '0;
    mul_flags[FLAG_OVF]   = !((&mul_hi) || !(|mul_hi));
    mul_flags[FLAG_NEG]   = mul_p[2*BW-1];
    mul_flags[FLAG_ZERO]  = ~|mul_p;
  end

  assign in_ready = (state_q == S_IDLE) || (state_q == S_DONE && out_ready && !mul_busy);
`else
  assign in_ready = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
`endif

  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign flags     = flags_q;
  assign out_err   = err_q;

  // Single-cycle datapath at BW+1 bits so carries/borrows are never lost.
  always_comb begin
    ax    = {in_a[BW-1], in_a};
    bx    = {in_b[BW-1], in_b};
    res   = '0;
    err_c = 1'b0;
    case (op_e'(opcode))
      OP_ADD:         res = ax + bx;
      OP_SUB, OP_CMP: res = ax - bx;
      OP_AND:         res = ax & bx;
      OP_OR:          res = ax | bx;
      OP_XOR:         res = ax ^ bx;
      OP_INC:         res = ax + (BW+1)'(1);
      OP_PASSA:       res = ax;
      OP_PASSB:       res = bx;
      OP_SHL:         res = ax << in_b[SHW-1:0];
      OP_SRA:         res = ax >>> in_b[SHW-1:0];
      default:        err_c = 1'b1;
    endcase
    arith = (op_e'(opcode) == OP_ADD) || (op_e'(opcode) == OP_SUB) ||
            (op_e'(opcode) == OP_CMP) || (op_e'(opcode) == OP_INC);
    ovf_c = arith && (res[BW] ^ res[BW-1]);
    single_out   = (err_c || op_e'(opcode) == OP_CMP) ? '0 : {{(BW-1){res[BW]}}, res};
    single_flags = '0;
    if (err_c) begin
      single_flags[FLAG_ZERO] = 1'b1;
    end else begin
      single_flags[FLAG_OVF]  = ovf_c;
      single_flags[FLAG_NEG]  = res[BW];
      single_flags[FLAG_ZERO] = ~|res;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    flags_d     = flags_q;
    err_d       = err_q;
`ifdef ALU_SEQ_MUL_EN
    mul_start   = 1'b0;
`endif
    case (state_q)
      S_MUL: begin
`ifdef ALU_SEQ_MUL_EN
        if (mul_done) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          out_d       = mul_p;
          flags_d     = mul_flags;
          err_d       = 1'b0;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: begin
        // IDLE, or DONE with the pending result being taken this cycle.
        if (state_q == S_IDLE || out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          if (accept) begin
`ifdef ALU_SEQ_MUL_EN
            if (op_e'(opcode) == OP_MUL) begin
              state_d   = S_MUL;
              mul_start = 1'b1;
            end else
`endif
            begin
              state_d     = S_DONE;
              out_valid_d = 1'b1;
              out_d       = single_out;
              flags_d     = single_flags;
              err_d       = err_c;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed plus randomized self-checking bench for alu_seq (follows ALU_SEQ_MUL_EN)
module tb_alu_seq;

  localparam int BW = 16;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  localparam longint MAXV = (longint'(1) << (BW - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (BW - 1));

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [BW-1:0]   in_a, in_b;
  logic [3:0]      opcode;
  logic            out_valid;
  logic            out_ready;
  logic [2*BW-1:0] out;
  logic [2:0]      flags;
  logic            out_err;

  int n_vec = 0;
  int n_err = 0;

  alu_seq #(.BW(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint wrap(input longint v, input int n);
    longint m;
    m = longint'(1) << n;
    v = v & (m - 1);
    if (v >= m / 2) v = v - m;
    return v;
  endfunction

  // Expected {err, flags, out} from integer arithmetic on the signed operands.
  function automatic logic [2*BW+3:0] model(input logic [3:0] op, input logic [BW-1:0] a,
                                            input logic [BW-1:0] b);
    longint A, B, r, o;
    int sh;
    bit ovf;
    A  = longint'($signed(a));
    B  = longint'($signed(b));
    sh = int'(b) % BW;
    case (op)
      4'd0:  r = A + B;
      4'd1:  r = A - B;
      4'd2:  r = A & B;
      4'd3:  r = A | B;
      4'd4:  r = A ^ B;
      4'd5:  r = A + 1;
      4'd6:  r = A;
      4'd7:  r = B;
      4'd8:  r = wrap(A <<< sh, BW + 1);
      4'd9:  r = A >>> sh;
      4'd10: r = A - B;
      4'd11: begin
        if (!MUL_EN) return {1'b1, 3'b001, {(2*BW){1'b0}}};
        r = A * B;
      end
      default: return {1'b1, 3'b001, {(2*BW){1'b0}}};
    endcase
    ovf = (op == 4'd0 || op == 4'd1 || op == 4'd5 || op == 4'd10 || op == 4'd11) &&
          (r > MAXV || r < MINV);
    o = (op == 4'd10) ? 0 : r;
    return {1'b0, ovf, r < 0, r == 0, o[2*BW-1:0]};
  endfunction

  task automatic do_op(input logic [3:0] op, input logic [BW-1:0] a, input logic [BW-1:0] b,
                       input int stall, input string tag);
    logic [2*BW+3:0] e;
    int k, lat;
    bit is_mul;
    e = model(op, a, b);
    is_mul = MUL_EN && (op == 4'd11);
    @(negedge clk);
    in_valid = 1'b1; opcode = op; in_a = a; in_b = b; out_ready = (stall == 0);
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    check($sformatf("%s.in_ready", tag), in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = BW'($urandom); in_b = BW'($urandom); opcode = 4'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid) check($sformatf("%s.busy_in_ready", tag), in_ready, 0);
    end while (!out_valid && lat < 40);
    check($sformatf("%s.latency", tag), lat, is_mul ? BW + 1 : 1);
    check($sformatf("%s.out", tag), out, e[2*BW-1:0]);
    check($sformatf("%s.flags", tag), flags, e[2*BW+2:2*BW]);
    check($sformatf("%s.err", tag), out_err, e[2*BW+3]);
    for (int s = 0; s < stall; s++) begin
      check($sformatf("%s.stall_in_ready", tag), in_ready, 0);
      @(negedge clk);
      check($sformatf("%s.stall_hold", tag), {out_valid, out_err, flags, out},
            {1'b1, e[2*BW+3], e[2*BW+2:2*BW], e[2*BW-1:0]});
    end
    out_ready = 1'b1;
    @(negedge clk);
    check($sformatf("%s.drained", tag), out_valid, 0);
  endtask

  initial begin
    logic [BW-1:0] corner [6];
    int seen;
    corner = '{16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, 16'h0001, 16'h000F};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0; opcode = '0;
    repeat (2) @(negedge clk);
    check("reset.out_valid", out_valid, 0);
    check("reset.out", out, 0);
    check("reset.flags", flags, 0);
    check("reset.err", out_err, 0);
    check("reset.in_ready", in_ready, 1);
    rst = 1'b0;

    do_op(4'd0, 16'h7FFF, 16'h0001, 0, "add_ovf");
    check("add_ovf.const", {flags, out}, {3'b100, 32'h0000_8000});

    @(negedge clk);
    in_valid = 1'b1; opcode = 4'd1; in_a = 16'd5; in_b = 16'd5; out_ready = 1'b1;
    @(negedge clk);
    check("b2b.sub", {out_valid, flags, out}, {1'b1, 3'b001, 32'h0});
    check("b2b.in_ready", in_ready, 1);
    opcode = 4'd10; in_a = 16'hFFFD; in_b = 16'd4;
    @(negedge clk);
    check("b2b.cmp", {out_valid, flags, out}, {1'b1, 3'b010, 32'h0});
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b.drained", out_valid, 0);

    do_op(4'd11, 16'hFED4, 16'd200, 0, "mul");
    if (MUL_EN) check("mul.const", {flags, out}, {3'b110, 32'hFFFF_15A0});
    else check("mul_dis.const", {out_err, flags, out}, {1'b1, 3'b001, 32'h0});

    do_op(4'd0, 16'h1234, 16'h0101, 5, "stall");
    do_op(4'd13, 16'h1111, 16'h2222, 0, "illegal");

`ifdef ALU_SEQ_MUL_EN
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'd11; in_a = 16'd123; in_b = 16'hFFF9; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mul_abort.outputs", {out_valid, out_err, flags, out}, 0);
    check("mul_abort.in_ready", in_ready, 1);
    rst = 1'b0;
    seen = 0;
    repeat (25) begin @(negedge clk); if (out_valid) seen++; end
    check("mul_abort.no_beat", seen, 0);
`endif

    for (int i = 0; i < 80; i++) begin
      logic [BW-1:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : BW'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : BW'($urandom);
      do_op(4'($urandom_range(0, 15)), ra, rb, $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
